// File: rtl/sift_pkg.sv
// Shared SIFT types: DoG pixel width/type, extrema FSM states, 3x3 neighbour offset table.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sift_pkg;

    // DoG pixels are signed 9-bit; the DoG writer uses the same width.
    localparam int DOG_W = 9;

    typedef logic signed [DOG_W-1:0] dog_pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2
    } ext_state_t;

    // Neighbour offsets in raster order, (-1,-1) .. (1,1); entry 4 is the centre column.
    function automatic logic signed [1:0] off_dy(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2: off_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: off_dy = 2'sd0;
            default:          off_dy = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] off_dx(input logic [3:0] i);
        case (i)
            4'd0, 4'd3, 4'd6: off_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: off_dx = 2'sd0;
            default:          off_dx = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/dog_neighbour_cmp.sv
// Running is_max/is_min flags for one candidate pixel against its neighbours from three scales.
// Latency: flags register on i_upd; o_keep is the combinational post-update survival flag.
// Backpressure: none; updates only when the controller pulses i_upd.
//
// Ports: clk, rst_in (sync active-low); i_init sets both flags; i_upd folds in one sample of
// i_prev/i_curr/i_next against centre i_c; i_is_centre skips the curr-scale compare (that is c
// itself); o_keep = (next is_max) | (next is_min).
module dog_neighbour_cmp
    import sift_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    i_init,
    input  logic                    i_upd,
    input  logic signed [DOG_W-1:0] i_c,
    input  logic signed [DOG_W-1:0] i_prev,
    input  logic signed [DOG_W-1:0] i_curr,
    input  logic signed [DOG_W-1:0] i_next,
    input  logic                    i_is_centre,
    output logic                    o_keep
);

    logic r_is_max;
    logic r_is_min;
    logic w_max_ok;
    logic w_min_ok;
    logic w_nxt_max;
    logic w_nxt_min;

    // Strict compares: any neighbour equal to c kills the corresponding flag.
    assign w_max_ok  = (i_c > i_prev) && (i_c > i_next) && (i_is_centre || (i_c > i_curr));
    assign w_min_ok  = (i_c < i_prev) && (i_c < i_next) && (i_is_centre || (i_c < i_curr));
    assign w_nxt_max = r_is_max && w_max_ok;
    assign w_nxt_min = r_is_min && w_min_ok;
    assign o_keep    = w_nxt_max || w_nxt_min;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_is_max <= 1'b0;
            r_is_min <= 1'b0;
        end else if (i_init) begin
            r_is_max <= 1'b1;
            r_is_min <= 1'b1;
        end else if (i_upd) begin
            r_is_max <= w_nxt_max;
            r_is_min <= w_nxt_min;
        end
    end

endmodule

// File: rtl/dog_extrema.sv
// Scans interior pixels of the curr DoG level and emits 3x3x3 extrema above a contrast threshold.
// Latency: 3 cycles per read (2-cycle BRAM + sample); 3..30 cycles per pixel plus EMIT.
// Backpressure: kp_valid/kp_x/kp_y held in EMIT until kp_ready; scan stalls meanwhile.
//
// Ports: clk, rst_in (sync active-low), start (pulse, IDLE only); address -> all three BRAMs;
// prev_pix/curr_pix/next_pix <- BRAM data; kp_valid/kp_ready/kp_x/kp_y keypoint handshake;
// busy (start..done), done (1-cycle pulse), state_num (debug 0 IDLE/1 READ/2 EMIT).
module dog_extrema
    import sift_pkg::*;
#(
    parameter int DIMENSION       = 64,
    parameter int CONTRAST_THRESH = 3
)
(
    input  logic                                   clk,
    input  logic                                   rst_in,
    input  logic                                   start,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0] address,
    input  logic signed [DOG_W-1:0]                prev_pix,
    input  logic signed [DOG_W-1:0]                curr_pix,
    input  logic signed [DOG_W-1:0]                next_pix,
    output logic                                   kp_valid,
    input  logic                                   kp_ready,
    output logic [$clog2(DIMENSION)-1:0]           kp_x,
    output logic [$clog2(DIMENSION)-1:0]           kp_y,
    output logic                                   busy,
    output logic                                   done,
    output logic [1:0]                             state_num
);

    localparam int              AW   = $clog2(DIMENSION*DIMENSION);
    localparam int              CW   = $clog2(DIMENSION);
    localparam logic [DOG_W:0]  C_TH = (DOG_W+1)'(CONTRAST_THRESH);

    ext_state_t      r_state;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic [1:0]      r_cnt;
    logic [3:0]      r_idx;
    dog_pix_t        r_c;
    logic [AW-1:0]   r_addr;
    logic            r_kp_vld;
    logic [CW-1:0]   r_kp_x;
    logic [CW-1:0]   r_kp_y;
    logic            r_busy;
    logic            r_done;

    logic [DOG_W:0]  w_c_ext;
    logic [DOG_W:0]  w_abs;
    logic            w_low;
    logic            w_sample;
    logic            w_init;
    logic            w_nbr_upd;
    logic            w_is_centre;
    logic            w_keep;
    logic            w_advance;
    logic            w_wrap;
    logic            w_last;
    logic [CW-1:0]   w_nx;
    logic [CW-1:0]   w_ny;

    function automatic logic [AW-1:0] f_addr(input logic [CW-1:0]   fx,
                                             input logic [CW-1:0]   fy,
                                             input logic signed [1:0] fdx,
                                             input logic signed [1:0] fdy);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        // Offsets are sign-extended; interior centres keep the sum non-negative.
        row = AW'(fy) + AW'(fdy);
        col = AW'(fx) + AW'(fdx);
        return row * AW'(DIMENSION) + col;
    endfunction

    // |c| in one extra bit so that -256 maps to 256 rather than wrapping.
    assign w_c_ext   = {curr_pix[DOG_W-1], curr_pix};
    assign w_abs     = curr_pix[DOG_W-1] ? (~w_c_ext + (DOG_W+1)'(1)) : w_c_ext;
    assign w_low     = (w_abs < C_TH);

    // BRAM data for the held address is valid on the third cycle of each read.
    assign w_sample    = (r_state == READ) && (r_cnt == 2'd2);
    assign w_init      = w_sample && (r_idx == 4'd0) && !w_low;
    assign w_nbr_upd   = w_sample && (r_idx != 4'd0);
    assign w_is_centre = (r_idx == 4'd5);

    assign w_advance = (w_sample && (r_idx == 4'd0) && w_low)
                    || (w_nbr_upd && !w_keep)
                    || ((r_state == EMIT) && r_kp_vld && kp_ready);

    assign w_wrap = (r_x == CW'(DIMENSION-2));
    assign w_last = w_wrap && (r_y == CW'(DIMENSION-2));
    assign w_nx   = w_wrap ? CW'(1) : r_x + CW'(1);
    assign w_ny   = w_wrap ? r_y + CW'(1) : r_y;

    dog_neighbour_cmp u_cmp (
        .clk         (clk),
        .rst_in      (rst_in),
        .i_init      (w_init),
        .i_upd       (w_nbr_upd),
        .i_c         (r_c),
        .i_prev      (prev_pix),
        .i_curr      (curr_pix),
        .i_next      (next_pix),
        .i_is_centre (w_is_centre),
        .o_keep      (w_keep)
    );

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_state  <= IDLE;
            r_x      <= CW'(1);
            r_y      <= CW'(1);
            r_cnt    <= 2'd0;
            r_idx    <= 4'd0;
            r_c      <= '0;
            r_addr   <= '0;
            r_kp_vld <= 1'b0;
            r_kp_x   <= '0;
            r_kp_y   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= READ;
                        r_busy  <= 1'b1;
                        r_x     <= CW'(1);
                        r_y     <= CW'(1);
                        r_addr  <= AW'(DIMENSION + 1);
                        r_cnt   <= 2'd0;
                        r_idx   <= 4'd0;
                    end
                end
                READ: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt + 2'd1;
                    end else if (r_idx == 4'd0) begin
                        if (!w_low) begin
                            r_c    <= curr_pix;
                            r_idx  <= 4'd1;
                            r_addr <= f_addr(r_x, r_y, off_dx(4'd0), off_dy(4'd0));
                            r_cnt  <= 2'd0;
                        end
                    end else if (w_keep) begin
                        if (r_idx == 4'd9) begin
                            r_state  <= EMIT;
                            r_kp_vld <= 1'b1;
                            r_kp_x   <= r_x;
                            r_kp_y   <= r_y;
                        end else begin
                            // idx k samples table entry k-1, so the next read uses entry r_idx.
                            r_idx  <= r_idx + 4'd1;
                            r_addr <= f_addr(r_x, r_y, off_dx(r_idx), off_dy(r_idx));
                            r_cnt  <= 2'd0;
                        end
                    end
                end
                EMIT: begin
                    if (kp_ready) begin
                        r_kp_vld <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Shared pixel-end path: rejects, completed scans and keypoint handshakes.
            if (w_advance) begin
                r_cnt <= 2'd0;
                r_idx <= 4'd0;
                if (w_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_addr  <= '0;
                    r_x     <= CW'(1);
                    r_y     <= CW'(1);
                end else begin
                    r_state <= READ;
                    r_x     <= w_nx;
                    r_y     <= w_ny;
                    r_addr  <= f_addr(w_nx, w_ny, 2'sd0, 2'sd0);
                end
            end
        end
    end

    assign address   = r_addr;
    assign kp_valid  = r_kp_vld;
    assign kp_x      = r_kp_x;
    assign kp_y      = r_kp_y;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state_num = r_state;

endmodule

// File: tb/tb_dog_extrema.sv
module tb_dog_extrema;

    localparam int D  = 4;
    localparam int TH = 3;
    localparam int AW = 4;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   rst_in = 1'b0;
    logic                   start = 1'b0;
    logic                   kp_ready = 1'b0;
    logic [AW-1:0]          address;
    logic signed [8:0]      prev_pix, curr_pix, next_pix;
    logic signed [8:0]      p1, c1, n1;
    logic                   kp_valid;
    logic [CW-1:0]          kp_x, kp_y;
    logic                   busy, done;
    logic [1:0]             state_num;

    logic signed [8:0]      prev_mem [0:D*D-1];
    logic signed [8:0]      curr_mem [0:D*D-1];
    logic signed [8:0]      next_mem [0:D*D-1];

    logic [2*CW-1:0]        exp_q [$];
    logic [2*CW-1:0]        exp_kp;
    int                     n_pass = 0;
    int                     n_total = 0;
    int                     kp_seen = 0;

    always #5 clk = ~clk;

    dog_extrema #(.DIMENSION(D), .CONTRAST_THRESH(TH)) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .start     (start),
        .address   (address),
        .prev_pix  (prev_pix),
        .curr_pix  (curr_pix),
        .next_pix  (next_pix),
        .kp_valid  (kp_valid),
        .kp_ready  (kp_ready),
        .kp_x      (kp_x),
        .kp_y      (kp_y),
        .busy      (busy),
        .done      (done),
        .state_num (state_num)
    );

    // Two-cycle read-latency BRAM model.
    always_ff @(posedge clk) begin
        p1       <= prev_mem[address];
        c1       <= curr_mem[address];
        n1       <= next_mem[address];
        prev_pix <= p1;
        curr_pix <= c1;
        next_pix <= n1;
    end

    // Scoreboard: pop one expected keypoint per handshake.
    always @(negedge clk) begin
        if (rst_in && kp_valid && kp_ready) begin
            kp_seen++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL kp_unexpected: got (%0d,%0d), required no keypoint", kp_x, kp_y);
            end else begin
                exp_kp = exp_q.pop_front();
                if ({kp_x, kp_y} !== exp_kp)
                    $display("FAIL kp_coord: got (%0d,%0d), required (%0d,%0d)",
                             kp_x, kp_y, exp_kp[2*CW-1:CW], exp_kp[CW-1:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1);
    end

    function automatic logic signed [8:0] pick(input int z, input int a);
        if (z == 0) return prev_mem[a];
        if (z == 1) return curr_mem[a];
        return next_mem[a];
    endfunction

    // Reference: full 26-neighbour test, no early exit.
    function automatic bit is_kp(input int x, input int y);
        int c, a, n;
        bit mx, mn;
        c  = curr_mem[y*D+x];
        a  = (c < 0) ? -c : c;
        if (a < TH) return 1'b0;
        mx = 1'b1;
        mn = 1'b1;
        for (int z = 0; z < 3; z++)
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    if (!(z == 1 && dy == 0 && dx == 0)) begin
                        n = pick(z, (y+dy)*D + (x+dx));
                        if (n >= c) mx = 1'b0;
                        if (n <= c) mn = 1'b0;
                    end
                end
        return mx | mn;
    endfunction

    task automatic clear_mems;
        for (int i = 0; i < D*D; i++) begin
            prev_mem[i] = '0;
            curr_mem[i] = '0;
            next_mem[i] = '0;
        end
    endtask

    task automatic load_expected;
        for (int y = 1; y <= D-2; y++)
            for (int x = 1; x <= D-2; x++)
                if (is_kp(x, y)) exp_q.push_back({CW'(x), CW'(y)});
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // cyc = number of negedges up to and including the one showing done.
    task automatic wait_done(input int bound, output int cyc);
        bit fin;
        fin = 1'b0;
        cyc = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                fin = 1'b1;
            end else if (cyc >= bound) begin
                n_total++;
                $display("FAIL done_timeout: no done after %0d cycles, required done pulse", cyc);
                fin = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (address !== '0) $display("FAIL reset_addr: got %0d, required 0", address);
        else n_pass++;
        n_total++;
        if ({kp_valid, busy, done} !== 3'b000)
            $display("FAIL reset_ctrl: got kp_valid/busy/done=%b, required 000", {kp_valid, busy, done});
        else n_pass++;
        n_total++;
        if ({kp_x, kp_y, state_num} !== '0)
            $display("FAIL reset_kp_state: got x=%0d y=%0d st=%0d, required 0 0 0", kp_x, kp_y, state_num);
        else n_pass++;
        @(posedge clk);
        #1 rst_in = 1'b1;
    endtask

    task automatic test_all_zero;
        int exp_addr [4] = '{5, 6, 9, 10};
        clear_mems();
        kp_ready = 1'b1;
        load_expected();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_total++;
            if (address !== AW'(exp_addr[i/3]) || busy !== 1'b1 || kp_valid !== 1'b0 || state_num !== 2'd1)
                $display("FAIL zero_scan_c%0d: got addr=%0d busy=%b kpv=%b st=%0d, required addr=%0d busy=1 kpv=0 st=1",
                         i, address, busy, kp_valid, state_num, exp_addr[i/3]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b1 || address !== '0 || state_num !== 2'd0)
            $display("FAIL zero_done: got busy=%b done=%b addr=%0d st=%0d, required 0 1 0 0",
                     busy, done, address, state_num);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0) $display("FAIL zero_done_pulse: got done=%b, required 0", done);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL zero_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_single_max;
        int cyc;
        clear_mems();
        curr_mem[5] = 9'sd50;
        kp_ready = 1'b1;
        load_expected();
        pulse_start();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (kp_valid !== 1'b1 && cyc < 200);
        n_total++;
        if (cyc != 31) $display("FAIL single_latency: got kp_valid at cycle %0d, required 31", cyc);
        else n_pass++;
        wait_done(200, cyc);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL single_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_tie;
        int cyc;
        clear_mems();
        curr_mem[10] = -9'sd40;
        prev_mem[5]  = -9'sd40;
        kp_ready = 1'b1;
        load_expected();
        pulse_start();
        wait_done(200, cyc);
        // 3 + 3 + 3 for rejected pixels, 6 for centre plus one neighbour read.
        n_total++;
        if (cyc - 1 != 15) $display("FAIL tie_busy: got %0d busy cycles, required 15", cyc - 1);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL tie_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stall;
        int cyc;
        clear_mems();
        curr_mem[5]  = 9'sd20;
        curr_mem[10] = -9'sd20;
        kp_ready = 1'b0;
        load_expected();
        pulse_start();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (kp_valid !== 1'b1 && cyc < 200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (kp_valid !== 1'b1 || kp_x !== CW'(1) || kp_y !== CW'(1) || state_num !== 2'd2)
                $display("FAIL stall_hold_c%0d: got kpv=%b x=%0d y=%0d st=%0d, required 1 1 1 2",
                         i, kp_valid, kp_x, kp_y, state_num);
            else n_pass++;
        end
        kp_ready = 1'b1;
        wait_done(200, cyc);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL stall_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_contrast;
        logic signed [8:0] vals [3];
        int                exp_n [3];
        int                cyc, seen0;
        vals[0] = 9'sd2;  exp_n[0] = 0;
        vals[1] = 9'sd3;  exp_n[1] = 1;
        vals[2] = 9'h100; exp_n[2] = 1;
        kp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clear_mems();
            curr_mem[5] = vals[i];
            load_expected();
            seen0 = kp_seen;
            pulse_start();
            wait_done(200, cyc);
            n_total++;
            if (kp_seen - seen0 != exp_n[i] || exp_q.size() != 0)
                $display("FAIL contrast_%0d: got %0d keypoints (%0d pending), required %0d",
                         vals[i], kp_seen - seen0, exp_q.size(), exp_n[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        clear_mems();
        curr_mem[6] = 9'sd50;
        kp_ready = 1'b1;
        load_expected();
        pulse_start();
        repeat (8) @(posedge clk);
        #1 rst_in = 1'b0;
        @(posedge clk);
        #1 rst_in = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_total++;
        if (address !== '0 || {kp_valid, busy, done} !== 3'b000 || {kp_x, kp_y} !== '0 || state_num !== 2'd0)
            $display("FAIL midreset_outs: got addr=%0d kpv/busy/done=%b st=%0d, required all 0",
                     address, {kp_valid, busy, done}, state_num);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL midreset_quiet_c%0d: got done=%b busy=%b, required 0 0", i, done, busy);
            else n_pass++;
        end
        load_expected();
        pulse_start();
        @(negedge clk);
        n_total++;
        if (address !== AW'(5)) $display("FAIL midreset_rescan: got addr=%0d, required 5", address);
        else n_pass++;
        wait_done(200, cyc);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL midreset_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        clear_mems();
        test_reset();
        test_all_zero();
        test_single_max();
        test_tie();
        test_stall();
        test_contrast();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
